// File: rtl/rec2pol_pkg.sv
// Shared constants for the iterative sequencer: FSM state encoding and default sizing.
package rec2pol_pkg;

  // Default iterations per operation and matching iteration-index width.
  localparam int unsigned DefaultNIter = 16;
  localparam int unsigned DefaultIterW = 6;

  // Sequencer state encoding.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: synchronous clear, increment, terminal-count flag at N_ITER-1.
// The count never leaves the range 0..N_ITER-1.
module iter_counter
  import rec2pol_pkg::*;
#(
  parameter int unsigned N_ITER = DefaultNIter,
  parameter int unsigned ITER_W = DefaultIterW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  output logic [ITER_W-1:0] count,
  output logic              tc
);

  localparam logic [ITER_W-1:0] LastIdx = ITER_W'(N_ITER - 1);

  logic [ITER_W-1:0] count_q;
  logic [ITER_W-1:0] count_d;

  // Next count: clear wins; incrementing from the terminal value returns to 0 instead of wrapping
  // through unused codes.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      if (count_q == LastIdx) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LastIdx);

endmodule

// File: rtl/iter_seq_control.sv
// Iterative-operation sequencer: IDLE -> RUN (N_ITER cycles) -> DONE (1 cycle), with a
// one-deep start queue, overrun reporting and abort.
module iter_seq_control
  import rec2pol_pkg::*;
#(
  parameter int unsigned N_ITER = DefaultNIter,
  parameter int unsigned ITER_W = DefaultIterW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              load,
  output logic              enable,
  output logic [ITER_W-1:0] iter,
  output logic              last,
  output logic              done,
  output logic              busy,
  output logic              pending,
  output logic              overrun
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       pending_q;
  logic       pending_d;
  logic       overrun_q;
  logic       overrun_d;

  logic       cnt_clear;
  logic       cnt_incr;
  logic       cnt_tc;
  logic       load_raw;
  logic       done_raw;

  iter_counter #(
    .N_ITER (N_ITER),
    .ITER_W (ITER_W)
  ) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .count (iter),
    .tc    (cnt_tc)
  );

  // Next-state, queue and strobe decode. Abort takes priority over start everywhere.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    load_raw  = 1'b0;
    done_raw  = 1'b0;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          load_raw  = 1'b1;
          state_d   = StRun;
          cnt_clear = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          pending_d = 1'b0;
          cnt_clear = 1'b1;
        end else begin
          if (cnt_tc) begin
            state_d   = StDone;
            cnt_clear = 1'b1;
          end else begin
            cnt_incr = 1'b1;
          end
          // One start may be queued; a second one while queued is dropped and reported.
          if (start) begin
            if (pending_q) begin
              overrun_d = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end
        end
      end
      StDone: begin
        cnt_clear = 1'b1;
        if (abort) begin
          state_d   = StIdle;
          pending_d = 1'b0;
        end else begin
          done_raw = 1'b1;
          if (pending_q || start) begin
            // Back-to-back launch; a fresh start alongside a queued one stays queued.
            load_raw  = 1'b1;
            state_d   = StRun;
            pending_d = pending_q && start;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        pending_d = 1'b0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // State, queue flag and overrun strobe registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Output decode. Reset forces IDLE, but load would still follow start in IDLE, so it is
  // gated directly to stay low while reset is held.
  always_comb begin
    enable  = (state_q == StRun);
    last    = (state_q == StRun) && cnt_tc;
    busy    = (state_q != StIdle);
    load    = load_raw && !reset;
    done    = done_raw;
    pending = pending_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_iter_seq_control.sv
// Scoreboard bench for iter_seq_control: three instances (N_ITER = 16, 4, 2) share one stimulus
// stream; a reference model pushes expected outputs per cycle, a monitor pops and compares.
module tb_iter_seq_control;

  typedef logic [2:0][12:0] rec_t;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic [2:0][12:0] obs;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned N = (g == 0) ? 16 : (g == 1) ? 4 : 2;
    localparam int unsigned W = (g == 0) ? 6 : (g == 1) ? 3 : 1;
    logic [W-1:0] it;
    logic ld, en, ls, dn, bs, pd, ov;
    iter_seq_control #(
      .N_ITER (N),
      .ITER_W (W)
    ) u_dut (
      .clock   (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .load    (ld),
      .enable  (en),
      .iter    (it),
      .last    (ls),
      .done    (dn),
      .busy    (bs),
      .pending (pd),
      .overrun (ov)
    );
    assign obs[g] = {ld, en, 6'(it), ls, dn, bs, pd, ov};
  end

  // Reference model: ph = -1 idle, 0..N-1 running at that index, N = done cycle.
  int   n_tab[3] = '{16, 4, 2};
  int   ph[3];
  bit   pend[3];
  bit   ovr[3];
  int   cycle;
  rec_t exp_q[$];
  int   cyc_q[$];
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit s, input bit a, input bit r);
    rec_t rec;
    int n;
    bit run, dst, ld, dn, ovr_n;
    logic [5:0] it;
    for (int i = 0; i < 3; i++) begin
      n   = n_tab[i];
      run = (ph[i] >= 0) && (ph[i] < n);
      dst = (ph[i] == n);
      if (r) begin
        rec[i] = '0;
        ph[i]  = -1;
        pend[i] = 1'b0;
        ovr[i] = 1'b0;
      end else begin
        ld = !a && (((ph[i] < 0) && s) || (dst && (pend[i] || s)));
        dn = dst && !a;
        it = run ? 6'(ph[i]) : 6'd0;
        rec[i] = {ld, run, it, run && (ph[i] == n - 1), dn, ph[i] >= 0, pend[i], ovr[i]};
        ovr_n = 1'b0;
        if (a) begin
          ph[i] = -1;
          pend[i] = 1'b0;
        end else if (ph[i] < 0) begin
          ph[i] = s ? 0 : -1;
        end else if (run) begin
          if (s) begin
            if (pend[i]) ovr_n = 1'b1;
            else pend[i] = 1'b1;
          end
          ph[i] = ph[i] + 1;
        end else begin
          if (pend[i] || s) begin
            pend[i] = pend[i] && s;
            ph[i] = 0;
          end else begin
            ph[i] = -1;
          end
        end
        ovr[i] = ovr_n;
      end
    end
    exp_q.push_back(rec);
    cyc_q.push_back(cycle);
    cycle++;
  endtask

  // One clock cycle: inputs change just after the rising edge, expectation is queued before
  // the falling edge where the monitor samples.
  task automatic cyc(input bit s, input bit a, input bit r);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
    reset = r;
    #2;
    model_step(s, a, r);
  endtask

  task automatic scen(input int len, input int s0, input int s1, input int s2, input int ab);
    for (int i = 0; i < len; i++) begin
      cyc((i == s0) || (i == s1) || (i == s2), i == ab, 1'b0);
    end
  endtask

  // Monitor: compare every instance against the queued expectation at each falling edge.
  initial begin
    rec_t rec;
    int c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        c   = cyc_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (obs[i] !== rec[i]) begin
            n_errors++;
            $display("FAIL outputs dut%0d (N=%0d) cycle %0d: got %b required %b", i, n_tab[i],
                     c, obs[i], rec[i]);
          end
        end
      end
    end
  end

  initial begin
    bit s, a, r;
    n_checks = 0;
    n_errors = 0;
    cycle    = 0;
    for (int i = 0; i < 3; i++) begin
      ph[i] = -1;
      pend[i] = 1'b0;
      ovr[i] = 1'b0;
    end
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;

    // Held in reset, including a start that must not produce load.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Single operation, then queued start, then overrun, then DONE with pending plus start.
    scen(40, 0, -1, -1, -1);
    scen(40, 0, 2, -1, -1);
    scen(40, 0, 2, 3, -1);
    scen(40, 0, 2, 5, -1);
    // Abort mid-run, and abort with start while idle.
    scen(30, 0, -1, -1, 8);
    scen(5, 0, -1, -1, 0);

    // Reset raised mid-cycle 5 of a run, then a full operation after release.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    scen(30, 0, -1, -1, -1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 35);
      a = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) == 0);
      cyc(s, a, r);
    end
    cyc(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_seq_control.md
ITER_SEQ_CONTROL -- requirements
Module: iter_seq_control

Interface
REQ-001 Parameter N_ITER, default 16: iterations per operation, legal range 2..64.
REQ-002 Parameter ITER_W, default 6: width of iter output, SHALL satisfy 2^ITER_W >= N_ITER.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one operation, single-cycle pulse.
REQ-006 abort  input  1  cancel current and pending operation.
REQ-007 load  output  1  one-cycle pulse, datapath captures operands.
REQ-008 enable  output  1  datapath iteration enable.
REQ-009 iter  output  ITER_W  current iteration index, shift amount/ROM address.
REQ-010 last  output  1  high while iter == N_ITER-1 and enable high.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 pending  output  1  one queued start held.
REQ-014 overrun  output  1  one-cycle pulse, start discarded.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; encoding from the shared package.
REQ-016 IDLE, start=1, abort=0: load=1 combinationally in that cycle; next state RUN, iter=0.
REQ-017 RUN: enable=1; iter increments by 1 per cycle from 0 to N_ITER-1; at iter==N_ITER-1 next state DONE, iter returns to 0.
REQ-018 DONE lasts exactly one cycle with done=1, enable=0.
REQ-019 Latency: start in cycle 0 gives enable in cycles 1..N_ITER and done in cycle N_ITER+1.
REQ-020 start in RUN with pending=0 SHALL set pending next cycle; no effect on iter.
REQ-021 start in RUN with pending=1 SHALL be discarded and overrun=1 in the following cycle.
REQ-022 DONE with pending=1 or start=1: load=1 in the DONE cycle, pending cleared, next state RUN with iter=0; throughput N_ITER+1 cycles/operation.
REQ-023 DONE with pending=1 and start=1 in the same cycle: pending consumed, start re-queued (pending stays 1).
REQ-024 DONE with no pending and no start: next state IDLE.
REQ-025 abort in RUN or DONE: next state IDLE, iter=0, pending=0; done and load suppressed in that cycle.
REQ-026 abort has priority over start in the same cycle; in IDLE abort+start gives no load and state stays IDLE.
REQ-027 enable, last, load, done and busy SHALL be combinational decodes of state, counter, start, pending and abort only.
REQ-028 iter SHALL never exceed N_ITER-1; counter SHALL be ITER_W bits with no wrap beyond N_ITER-1.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, iter=0, pending=0, overrun=0.
REQ-030 While reset is high: load, enable, last, done, busy all 0 regardless of start.
REQ-031 Reset asserted mid-RUN SHALL drop enable within the same cycle; no done pulse follows.

Structure
REQ-032 Shared package rec2pol_pkg SHALL hold state encoding constants and the default N_ITER/ITER_W values.
REQ-033 One sub-module iter_counter (clear, increment, terminal-count flag, parametrised by N_ITER/ITER_W) SHALL hold the iteration counter.

Verification
REQ-034 N_ITER=16, start at cycle 0 -> load cycle 0, enable cycles 1..16, iter 0..15, last cycle 16, done cycle 17, busy 1..17.
REQ-035 N_ITER=4, start at cycle 0 and cycle 2 -> pending=1 from cycle 3, done cycle 5 with load cycle 5, second done cycle 10, no overrun.
REQ-036 N_ITER=4, start at cycles 0, 2, 3 -> overrun pulse cycle 4 only, exactly two done pulses (cycles 5, 10).
REQ-037 N_ITER=16, start cycle 0, abort cycle 8 -> enable low from cycle 9, iter=0, no done, busy=0 at cycle 9.
REQ-038 N_ITER=16, reset asserted asynchronously mid-cycle 5 of RUN -> all outputs 0 immediately; start after release runs full 17-cycle operation.
REQ-039 N_ITER=2 boundary: start cycle 0 -> enable cycles 1..2, last cycle 2, done cycle 3.
